// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx_if
// Brief   : 16-bit AXI4-Stream sample bus feeding the I2S transmitter.
// Revision: 1.0 - initial release
// ============================================================================
interface i2s_tx_if;
    logic        tvalid;
    logic [15:0] tdata;
    logic        tready;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx
// Brief   : Mono-to-stereo I2S transmitter with one-entry sample buffer and
//           underrun flag. Define I2S_TX_HOLD_LAST_EN to repeat the last
//           sample on underrun instead of sending silence.
// Revision: 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    i2s_tx_if.slave   s_axis,
    output logic      bclk,
    output logic      lrclk,
    output logic      sdata,
    output logic      underrun
);

    localparam int                 c_CNT_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BCLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bclk;
    logic [4:0]         r_slot;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_underrun;
    logic [31:0]        r_shift;
    logic [15:0]        r_buf;
    logic               r_full;

    logic               w_tick;
    logic               w_fall;
    logic               w_load;
    logic               w_hs;
    logic [4:0]         w_slot_nxt;
    logic [15:0]        w_fill;
    logic [31:0]        w_shift_nxt;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [15:0]        r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 16'h0000;
        end else if (w_load && r_full) begin
            r_last <= r_buf;
        end
    end

    assign w_fill = r_last;
`else
    assign w_fill = 16'h0000;
`endif

    // A fall event is the divider wrap that takes bclk from 1 to 0; the frame
    // is (re)loaded on the fall event that enters slot 1.
    always_comb begin
        w_tick     = (r_cnt == c_CNT_MAX);
        w_fall     = w_tick && r_bclk;
        w_load     = w_fall && (r_slot == 5'd0);
        w_hs       = s_axis.tvalid && !r_full;
        w_slot_nxt = r_slot + 5'd1;
        if (w_load) begin
            w_shift_nxt = r_full ? {r_buf, r_buf} : {w_fill, w_fill};
        end else begin
            w_shift_nxt = {r_shift[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_cnt  <= r_cnt + c_CNT_W'(1);
        end
    end

    // sdata takes the post-load/post-shift MSB so the left MSB lands in slot 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot  <= 5'd0;
            r_lrclk <= 1'b0;
            r_shift <= 32'h0000_0000;
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            r_slot  <= w_slot_nxt;
            r_lrclk <= w_slot_nxt[4];
            r_shift <= w_shift_nxt;
            r_sdata <= w_shift_nxt[31];
        end
    end

    // A load with the buffer empty takes the underrun path even if a sample
    // is captured on the same edge; that sample waits for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_buf  <= 16'h0000;
        end else if (w_load && r_full) begin
            r_full <= 1'b0;
        end else if (w_hs) begin
            r_full <= 1'b1;
            r_buf  <= s_axis.tdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load && !r_full;
        end
    end

    assign s_axis.tready = ~r_full;
    assign bclk          = r_bclk;
    assign lrclk         = r_lrclk;
    assign sdata         = r_sdata;
    assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_tx
// Brief   : Self-checking bench for i2s_tx with a frame-level scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int BD = 2;

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp;
        int          idle;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bclk, lrclk, sdata, underrun;

    i2s_tx_if s ();

    i2s_tx #(.BCLK_DIV(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_axis   (s.slave),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] drv_exp = 16'h0000;

    int          m_edge = 0;
    logic        m_full = 1'b0;
    logic [15:0] m_buf  = 16'h0000;
    logic [15:0] m_last = 16'h0000;
    logic        m_und  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit load_edge(input int e);
        return (e >= 2 * BD) && (((e - 2 * BD) % (64 * BD)) == 0);
    endfunction

    function automatic int cur_slot(input int e);
        return (e >= 2 * BD) ? ((((e - 2 * BD) / (2 * BD)) + 1) % 32) : 0;
    endfunction

    // Reference: frame starts at fixed clk-edge numbers, buffer occupancy tracked.
    initial begin
        bit          ld, hs;
        logic [15:0] fill;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_edge = 0; m_full = 1'b0; m_buf = 16'h0; m_last = 16'h0; m_und = 1'b0;
                exp_q.delete();
            end else begin
                ld = load_edge(m_edge + 1);
                hs = s.tvalid && !m_full;
                m_edge++;
                m_und = ld && !m_full;
`ifdef I2S_TX_HOLD_LAST_EN
                fill = m_last;
`else
                fill = 16'h0000;
`endif
                if (ld) begin
                    if (m_full) begin
                        exp_q.push_back(m_buf);
                        m_last = m_buf;
                        m_full = 1'b0;
                    end else begin
                        exp_q.push_back(fill);
                    end
                end
                if (hs) begin
                    m_full = 1'b1;
                    m_buf  = drv_exp;
                end
            end
        end
    end

    // Monitor: sample lrclk/sdata on each bclk rise, assemble 32-bit frames.
    initial begin
        int          k = 0;
        int          slot;
        logic        pb = 1'b0;
        logic [31:0] acc = 32'h0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                k = 0; pb = 1'b0; acc = 32'h0;
            end else begin
                chk("tready", s.tready, !m_full);
                chk("underrun", underrun, m_und);
                if (!pb && bclk) begin
                    k++;
                    slot = (k - 1) % 32;
                    chk("lrclk", lrclk, slot >= 16);
                    if (k >= 2) begin
                        acc = {acc[30:0], sdata};
                        if (slot == 0) begin
                            if (exp_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL frame actual %h required none-queued", acc);
                            end else begin
                                e = exp_q.pop_front();
                                chk("frame", acc, {e, e});
                            end
                        end
                    end
                end
                pb = bclk;
            end
        end
    end

    task automatic check_release();
        logic [5:0] eb = 6'b100110;
        logic [5:0] eu = 6'b001000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rel_bclk", bclk, eb[i]);
            chk("rel_underrun", underrun, eu[i]);
        end
    endtask

    task automatic send(input vec_t v);
        bit rdy;
        int n = 0;
        s.tdata  = v.data;
        drv_exp  = v.exp;
        s.tvalid = 1'b1;
        forever begin
            rdy = s.tready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 200 * BD) begin
                checks++; errors++;
                $display("FAIL handshake actual timeout required accept data %h", v.data);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        vecs[0] = '{data: 16'hA5C3, exp: 16'hA5C3, idle: 0};
        vecs[1] = '{data: 16'h8000, exp: 16'h8000, idle: 0};
        vecs[2] = '{data: 16'h7FFF, exp: 16'h7FFF, idle: 0};
        vecs[3] = '{data: 16'h1234, exp: 16'h1234, idle: 300};
        vecs[4] = '{data: 16'h0001, exp: 16'h0001, idle: 0};
        vecs[5] = '{data: 16'hFFFF, exp: 16'hFFFF, idle: 200};

        s.tvalid = 1'b0;
        s.tdata  = 16'h0000;
        #1;
        chk("rst_bclk", bclk, 1'b0);
        chk("rst_tready", s.tready, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_release();

        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            if (vecs[i].idle > 0) begin
                s.tvalid = 1'b0;
                repeat (vecs[i].idle) @(posedge clk);
                #1;
            end
        end

        // Handshake on the same edge as the slot-1 load with the buffer empty.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_edge(m_edge + 1) && n < 200 * BD);
        s.tdata  = 16'h5A0F;
        drv_exp  = 16'h5A0F;
        s.tvalid = 1'b1;
        @(posedge clk); #1;
        s.tvalid = 1'b0;
        chk("same_edge_underrun", underrun, 1'b1);
        chk("same_edge_tready", s.tready, 1'b0);
        repeat (200 * BD) @(posedge clk);

        // Asynchronous reset in slot 20 with a sample sitting in the buffer.
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cur_slot(m_edge) != 20 && n < 200 * BD);
        s.tdata  = 16'hBEEF;
        drv_exp  = 16'hBEEF;
        s.tvalid = 1'b1;
        @(posedge clk); #1;
        s.tvalid = 1'b0;
        chk("pre_rst_lrclk", lrclk, 1'b1);
        chk("pre_rst_tready", s.tready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_bclk", bclk, 1'b0);
        chk("async_lrclk", lrclk, 1'b0);
        chk("async_sdata", sdata, 1'b0);
        chk("async_underrun", underrun, 1'b0);
        chk("async_tready", s.tready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_release();
        repeat (160 * BD) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
